// File: rtl/vending_controller.sv
// vending_controller: coin-operated product vending FSM.
//
// Flow: a product selection in IDLE latches channel and price. COLLECT accumulates coins until
// the price is reached (DELIVER) or the customer cancels (REFUND). DELIVER hands the channel
// out over a valid/ack handshake. CHANGE returns any overpayment, and REFUND returns the whole
// credit, each over a second valid/ack handshake.
//
// Optional feature: define VEND_TIMEOUT_EN to build an inactivity counter that forces REFUND
// after TIMEOUT_CYCLES idle COLLECT cycles. Without it COLLECT waits indefinitely.
//
// Ports:
//   clk, resetN               clock, asynchronous active-low reset
//   selectValid/selectIdx     product selection strobe and channel
//   priceTable, stockEmpty    flat per-channel prices, per-channel sold-out flags
//   coinValid/coinValue       coin strobe and value
//   cancel                    customer abort
//   vendValid/vendIdx/vendAck dispense handshake
//   changeValid/changeValue/changeAck  change or refund handshake
//   coinReject, selReject     one-cycle rejection pulses
//   credit                    accumulated credit
//   stateIndicator            IDLE=0 COLLECT=1 DELIVER=2 CHANGE=3 REFUND=4
module vending_controller #(
    parameter int unsigned NUM_ITEMS      = 4,
    parameter int unsigned PRICE_W        = 8,
    parameter int unsigned COIN_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           selectValid,
    input  logic [$clog2(NUM_ITEMS)-1:0]   selectIdx,
    input  logic [NUM_ITEMS*PRICE_W-1:0]   priceTable,
    input  logic [NUM_ITEMS-1:0]           stockEmpty,
    input  logic                           coinValid,
    input  logic [COIN_W-1:0]              coinValue,
    input  logic                           cancel,
    output logic                           vendValid,
    output logic [$clog2(NUM_ITEMS)-1:0]   vendIdx,
    input  logic                           vendAck,
    output logic                           changeValid,
    output logic [PRICE_W-1:0]             changeValue,
    input  logic                           changeAck,
    output logic                           coinReject,
    output logic                           selReject,
    output logic [PRICE_W-1:0]             credit,
    output logic [2:0]                     stateIndicator
);
    localparam int unsigned IW = $clog2(NUM_ITEMS);

    if (NUM_ITEMS < 2 || NUM_ITEMS > 16 || TIMEOUT_CYCLES < 1 || COIN_W > PRICE_W) begin : g_bad_cfg
        $error("vending_controller: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StDeliver = 3'd2,
        StChange  = 3'd3,
        StRefund  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [PRICE_W-1:0] credit_q, credit_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               vend_valid_q, vend_valid_d;
    logic               change_valid_q, change_valid_d;
    logic [PRICE_W-1:0] change_value_q, change_value_d;
    logic               coin_reject_q, coin_reject_d;
    logic               sel_reject_q, sel_reject_d;

    logic               sel_hit, sel_empty;
    logic [PRICE_W-1:0] sel_price;
    logic [PRICE_W:0]   coin_sum;   // extra MSB flags credit overflow
    logic               coin_accept;
    logic               tmo_hit;

    // Explicit channel compare so out-of-range indices never index the price table.
    always_comb begin
        sel_hit   = 1'b0;
        sel_empty = 1'b0;
        sel_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (selectIdx == IW'(i)) begin
                sel_hit   = 1'b1;
                sel_empty = stockEmpty[i];
                sel_price = priceTable[i*PRICE_W +: PRICE_W];
            end
        end
    end

    assign coin_sum = {1'b0, credit_q} + (PRICE_W+1)'(coinValue);

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero outside COLLECT so every entry starts a fresh count.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == StCollect && !coin_accept) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == StCollect) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) tmo_cnt_q <= '0;
        else         tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        price_d       = price_q;
        idx_d         = idx_q;
        coin_reject_d = 1'b0;
        sel_reject_d  = 1'b0;
        coin_accept   = 1'b0;

        unique case (state_q)
            StIdle: begin
                coin_reject_d = coinValid;
                if (selectValid) begin
                    if (sel_hit && !sel_empty && sel_price != '0) begin
                        idx_d   = selectIdx;
                        price_d = sel_price;
                        state_d = StCollect;
                    end else begin
                        sel_reject_d = 1'b1;
                    end
                end
            end
            StCollect: begin
                if (coinValid) begin
                    if (coin_sum[PRICE_W]) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d    = coin_sum[PRICE_W-1:0];
                        coin_accept = 1'b1;
                    end
                end
                // Same-cycle coin is already in credit_d, so it is refunded or counts to price.
                if (cancel)                          state_d = StRefund;
                else if (credit_d >= price_q)        state_d = StDeliver;
                else if (tmo_hit && !coin_accept)    state_d = StRefund;
            end
            StDeliver: begin
                coin_reject_d = coinValid;
                if (vendAck && vend_valid_q) begin
                    state_d = (credit_q > price_q) ? StChange : StIdle;
                end
            end
            StChange: begin
                coin_reject_d = coinValid;
                if (changeAck && change_valid_q) state_d = StIdle;
            end
            StRefund: begin
                coin_reject_d = coinValid;
                if (credit_q == '0 || (changeAck && change_valid_q)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) credit_d = '0;

        // Registered handshake outputs are decoded from the next state.
        vend_valid_d   = (state_d == StDeliver);
        change_valid_d = (state_d == StChange) || (state_d == StRefund && credit_d != '0);
        change_value_d = '0;
        if (state_d == StChange)      change_value_d = credit_d - price_q;
        else if (state_d == StRefund) change_value_d = credit_d;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= StIdle;
            credit_q       <= '0;
            price_q        <= '0;
            idx_q          <= '0;
            vend_valid_q   <= 1'b0;
            change_valid_q <= 1'b0;
            change_value_q <= '0;
            coin_reject_q  <= 1'b0;
            sel_reject_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            price_q        <= price_d;
            idx_q          <= idx_d;
            vend_valid_q   <= vend_valid_d;
            change_valid_q <= change_valid_d;
            change_value_q <= change_value_d;
            coin_reject_q  <= coin_reject_d;
            sel_reject_q   <= sel_reject_d;
        end
    end

    assign vendValid      = vend_valid_q;
    assign vendIdx        = idx_q;
    assign changeValid    = change_valid_q;
    assign changeValue    = change_value_q;
    assign coinReject     = coin_reject_q;
    assign selReject      = sel_reject_q;
    assign credit         = credit_q;
    assign stateIndicator = state_q;

endmodule

// File: tb/tb_vending_controller.sv
module tb_vending_controller;
    localparam int NI = 5;
    localparam int PW = 8;
    localparam int CW = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          selectValid = 1'b0;
    logic [IW-1:0] selectIdx = '0;
    logic [NI*PW-1:0] priceTable;
    logic [NI-1:0] stockEmpty;
    logic          coinValid = 1'b0;
    logic [CW-1:0] coinValue = '0;
    logic          cancel = 1'b0;
    logic          vendValid;
    logic [IW-1:0] vendIdx;
    logic          vendAck = 1'b0;
    logic          changeValid;
    logic [PW-1:0] changeValue;
    logic          changeAck = 1'b0;
    logic          coinReject, selReject;
    logic [PW-1:0] credit;
    logic [2:0]    stateIndicator;

    int vectors = 0;
    int errors  = 0;

    // ch4=255, ch3=20 (sold out), ch2=25, ch1=12, ch0=0 (zero price)
    assign priceTable = {8'd255, 8'd20, 8'd25, 8'd12, 8'd0};
    assign stockEmpty = 5'b01000;

    always #5 clk = ~clk;

    vending_controller #(
        .NUM_ITEMS(NI), .PRICE_W(PW), .COIN_W(CW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .resetN(resetN), .selectValid(selectValid), .selectIdx(selectIdx),
        .priceTable(priceTable), .stockEmpty(stockEmpty), .coinValid(coinValid),
        .coinValue(coinValue), .cancel(cancel), .vendValid(vendValid), .vendIdx(vendIdx),
        .vendAck(vendAck), .changeValid(changeValid), .changeValue(changeValue),
        .changeAck(changeAck), .coinReject(coinReject), .selReject(selReject),
        .credit(credit), .stateIndicator(stateIndicator)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input int idx);
        selectValid = 1'b1; selectIdx = IW'(idx);
        tick();
        selectValid = 1'b0;
    endtask

    task automatic coin(input int v);
        coinValid = 1'b1; coinValue = CW'(v);
        tick();
        coinValid = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #12;
        vectors++;
        if (stateIndicator !== 3'd0 || credit !== 8'd0 || vendValid !== 1'b0 ||
            changeValid !== 1'b0 || coinReject !== 1'b0 || selReject !== 1'b0 ||
            vendIdx !== 3'd0 || changeValue !== 8'd0) begin
            errors++;
            $display("FAIL reset: state=%0d credit=%0d vv=%b cv=%b cr=%b sr=%b vi=%0d chg=%0d required all 0",
                     stateIndicator, credit, vendValid, changeValid, coinReject, selReject,
                     vendIdx, changeValue);
        end
        @(negedge clk);
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_idle_rejects();
        int bad [3] = '{3, 6, 0};
        coinValid = 1'b1; coinValue = 4'd5;
        tick();
        coinValid = 1'b0;
        vectors++;
        if (coinReject !== 1'b1 || credit !== 8'd0 || stateIndicator !== 3'd0) begin
            errors++;
            $display("FAIL idle_coin: cr=%b credit=%0d state=%0d required 1/0/0",
                     coinReject, credit, stateIndicator);
        end
        tick();
        vectors++;
        if (coinReject !== 1'b0) begin
            errors++; $display("FAIL idle_coin_pulse: cr=%b required 0", coinReject);
        end
        for (int i = 0; i < 3; i++) begin
            select(bad[i]);
            vectors++;
            if (selReject !== 1'b1 || stateIndicator !== 3'd0) begin
                errors++;
                $display("FAIL sel_reject idx %0d: sr=%b state=%0d required 1/0",
                         bad[i], selReject, stateIndicator);
            end
            tick();
            vectors++;
            if (selReject !== 1'b0) begin
                errors++; $display("FAIL sel_reject_pulse idx %0d: sr=%b required 0", bad[i], selReject);
            end
        end
        vendAck = 1'b1; changeAck = 1'b1;
        tick();
        vendAck = 1'b0; changeAck = 1'b0;
        vectors++;
        if (stateIndicator !== 3'd0 || vendValid !== 1'b0 || changeValid !== 1'b0) begin
            errors++; $display("FAIL idle_ack: state=%0d vv=%b cv=%b required 0/0/0",
                               stateIndicator, vendValid, changeValid);
        end
    endtask

    task automatic test_exact_price();
        select(2);
        vectors++;
        if (stateIndicator !== 3'd1 || credit !== 8'd0) begin
            errors++; $display("FAIL exact_sel: state=%0d credit=%0d required 1/0", stateIndicator, credit);
        end
        coin(10); coin(10);
        vectors++;
        if (credit !== 8'd20 || stateIndicator !== 3'd1 || vendValid !== 1'b0) begin
            errors++; $display("FAIL exact_partial: credit=%0d state=%0d vv=%b required 20/1/0",
                               credit, stateIndicator, vendValid);
        end
        coin(5);
        vectors++;
        if (stateIndicator !== 3'd2 || vendValid !== 1'b1 || vendIdx !== 3'd2 || credit !== 8'd25) begin
            errors++; $display("FAIL exact_deliver: state=%0d vv=%b vi=%0d credit=%0d required 2/1/2/25",
                               stateIndicator, vendValid, vendIdx, credit);
        end
        changeAck = 1'b1;
        tick();
        changeAck = 1'b0;
        vectors++;
        if (stateIndicator !== 3'd2 || vendValid !== 1'b1) begin
            errors++; $display("FAIL exact_hold: state=%0d vv=%b required 2/1", stateIndicator, vendValid);
        end
        vendAck = 1'b1;
        tick();
        vendAck = 1'b0;
        vectors++;
        if (stateIndicator !== 3'd0 || credit !== 8'd0 || vendValid !== 1'b0 || changeValid !== 1'b0) begin
            errors++; $display("FAIL exact_done: state=%0d credit=%0d vv=%b cv=%b required 0/0/0/0",
                               stateIndicator, credit, vendValid, changeValid);
        end
    endtask

    task automatic test_change();
        select(1); coin(10); coin(10);
        vendAck = 1'b1;
        tick();
        vendAck = 1'b0;
        vectors++;
        if (stateIndicator !== 3'd3 || changeValid !== 1'b1 || changeValue !== 8'd8 || vendValid !== 1'b0) begin
            errors++; $display("FAIL change: state=%0d cv=%b chg=%0d vv=%b required 3/1/8/0",
                               stateIndicator, changeValid, changeValue, vendValid);
        end
        coin(4);
        vectors++;
        if (coinReject !== 1'b1 || credit !== 8'd20 || changeValid !== 1'b1) begin
            errors++; $display("FAIL change_coin: cr=%b credit=%0d cv=%b required 1/20/1",
                               coinReject, credit, changeValid);
        end
        changeAck = 1'b1;
        tick();
        changeAck = 1'b0;
        vectors++;
        if (stateIndicator !== 3'd0 || credit !== 8'd0 || changeValid !== 1'b0) begin
            errors++; $display("FAIL change_done: state=%0d credit=%0d cv=%b required 0/0/0",
                               stateIndicator, credit, changeValid);
        end
    endtask

    task automatic test_cancel();
        select(1); coin(5);
        cancel = 1'b1; coinValid = 1'b1; coinValue = 4'd3;
        tick();
        cancel = 1'b0; coinValid = 1'b0;
        vectors++;
        if (stateIndicator !== 3'd4 || changeValid !== 1'b1 || changeValue !== 8'd8) begin
            errors++; $display("FAIL cancel_coin: state=%0d cv=%b chg=%0d required 4/1/8",
                               stateIndicator, changeValid, changeValue);
        end
        changeAck = 1'b1; tick(); changeAck = 1'b0;
        select(1); coin(10);
        cancel = 1'b1; coinValid = 1'b1; coinValue = 4'd5;
        tick();
        cancel = 1'b0; coinValid = 1'b0;
        vectors++;
        if (stateIndicator !== 3'd4 || changeValue !== 8'd15 || vendValid !== 1'b0) begin
            errors++; $display("FAIL cancel_wins: state=%0d chg=%0d vv=%b required 4/15/0",
                               stateIndicator, changeValue, vendValid);
        end
        changeAck = 1'b1; tick(); changeAck = 1'b0;
        vectors++;
        if (stateIndicator !== 3'd0 || credit !== 8'd0) begin
            errors++; $display("FAIL cancel_done: state=%0d credit=%0d required 0/0", stateIndicator, credit);
        end
        select(1);
        cancel = 1'b1; tick(); cancel = 1'b0;
        vectors++;
        if (stateIndicator !== 3'd4 || changeValid !== 1'b0) begin
            errors++; $display("FAIL refund_zero: state=%0d cv=%b required 4/0", stateIndicator, changeValid);
        end
        tick();
        vectors++;
        if (stateIndicator !== 3'd0 || changeValid !== 1'b0) begin
            errors++; $display("FAIL refund_zero_done: state=%0d cv=%b required 0/0", stateIndicator, changeValid);
        end
    endtask

    task automatic test_overflow();
        select(4);
        for (int i = 0; i < 16; i++) coin(15);
        coin(10);
        vectors++;
        if (credit !== 8'd250 || stateIndicator !== 3'd1) begin
            errors++; $display("FAIL ovf_fill: credit=%0d state=%0d required 250/1", credit, stateIndicator);
        end
        coin(9);
        vectors++;
        if (coinReject !== 1'b1 || credit !== 8'd250 || stateIndicator !== 3'd1) begin
            errors++; $display("FAIL ovf_reject: cr=%b credit=%0d state=%0d required 1/250/1",
                               coinReject, credit, stateIndicator);
        end
        select(3);
        vectors++;
        if (selReject !== 1'b0 || stateIndicator !== 3'd1) begin
            errors++; $display("FAIL collect_select: sr=%b state=%0d required 0/1", selReject, stateIndicator);
        end
`ifndef VEND_TIMEOUT_EN
        repeat (30) tick();
        vectors++;
        if (stateIndicator !== 3'd1 || credit !== 8'd250) begin
            errors++; $display("FAIL no_timeout: state=%0d credit=%0d required 1/250", stateIndicator, credit);
        end
`endif
        cancel = 1'b1; tick(); cancel = 1'b0;
        vectors++;
        if (stateIndicator !== 3'd4 || changeValue !== 8'd250) begin
            errors++; $display("FAIL ovf_refund: state=%0d chg=%0d required 4/250", stateIndicator, changeValue);
        end
        changeAck = 1'b1; tick(); changeAck = 1'b0;
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        select(1); coin(5);
        repeat (15) tick();
        vectors++;
        if (stateIndicator !== 3'd1) begin
            errors++; $display("FAIL timeout_early: state=%0d required 1", stateIndicator);
        end
        tick();
        vectors++;
        if (stateIndicator !== 3'd4 || changeValue !== 8'd5) begin
            errors++; $display("FAIL timeout: state=%0d chg=%0d required 4/5", stateIndicator, changeValue);
        end
        changeAck = 1'b1; tick(); changeAck = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        select(2); coin(15); coin(10);
        vectors++;
        if (stateIndicator !== 3'd2 || vendValid !== 1'b1) begin
            errors++; $display("FAIL mid_setup: state=%0d vv=%b required 2/1", stateIndicator, vendValid);
        end
        #2 resetN = 1'b0;
        #1;
        vectors++;
        if (stateIndicator !== 3'd0 || vendValid !== 1'b0 || credit !== 8'd0 || changeValid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: state=%0d vv=%b credit=%0d cv=%b required 0/0/0/0",
                               stateIndicator, vendValid, credit, changeValid);
        end
        @(negedge clk);
        resetN = 1'b1;
        tick();
        vectors++;
        if (stateIndicator !== 3'd0 || changeValid !== 1'b0) begin
            errors++; $display("FAIL mid_after: state=%0d cv=%b required 0/0", stateIndicator, changeValid);
        end
    endtask

    initial begin
        test_reset();
        test_idle_rejects();
        test_exact_price();
        test_change();
        test_cancel();
        test_overflow();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
